// File: rtl/ones_weight_enumerator_if.sv
// Handshake bundle for ones_weight_enumerator: start/weight request plus
// the word stream and run status returned by the enumerator.
interface ones_weight_enumerator_if;
  localparam int unsigned WORD_W  = 15;
  localparam int unsigned N_W     = 4;
  localparam int unsigned COUNT_W = 13;

  logic               start;
  logic [N_W-1:0]     n;
  logic [WORD_W-1:0]  word;
  logic               word_valid;
  logic               word_ready;
  logic [COUNT_W-1:0] count;
  logic               busy;
  logic               done;

  // Requester side: issues start/n and consumes words.
  modport master (
    output start,
    output n,
    output word_ready,
    input  word,
    input  word_valid,
    input  count,
    input  busy,
    input  done
  );

  // Enumerator side.
  modport slave (
    input  start,
    input  n,
    input  word_ready,
    output word,
    output word_valid,
    output count,
    output busy,
    output done
  );
endinterface

// File: rtl/ones_weight_enumerator.sv
// Enumerates every 15-bit word of a requested weight n in ascending order,
// one word per valid/ready handshake (Gosper's next-same-weight step).
module ones_weight_enumerator (
  input  logic                   clk,
  input  logic                   rst,
  ones_weight_enumerator_if.slave bus
);
  localparam int unsigned WORD_W  = 15;
  localparam int unsigned N_W     = 4;
  localparam int unsigned COUNT_W = 13;
  localparam int unsigned ARITH_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 word_valid_q, word_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ARITH_W-1:0]   x_ext;
  logic [ARITH_W-1:0]   low_bit_ext;
  logic [ARITH_W-1:0]   ripple_ext;
  logic [ARITH_W-1:0]   next_ext;
  logic [ARITH_W-1:0]   ones_ext;
  logic [ARITH_W-1:0]   last_ext;
  logic [ARITH_W-1:0]   first_ext;
  logic [N_W-1:0]       ctz;
  logic                 hs_c;
  logic                 is_last_c;

  // Next word of equal weight: c = x & -x, r = x + c, next = (((r^x)>>2)>>ctz(c)) | r.
  always_comb begin
    x_ext       = ARITH_W'(word_q);
    low_bit_ext = x_ext & (~x_ext + ARITH_W'(1));
    ripple_ext  = x_ext + low_bit_ext;
    ctz         = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (low_bit_ext[i]) begin
        ctz = N_W'(i);
      end
    end
    next_ext = (((ripple_ext ^ x_ext) >> 2) >> ctz) | ripple_ext;
  end

  // Last pattern of the latched weight: n ones packed against bit 14.
  always_comb begin
    ones_ext  = (ARITH_W'(1) << n_q) - ARITH_W'(1);
    last_ext  = ones_ext << (N_W'(WORD_W) - n_q);
    first_ext = (ARITH_W'(1) << bus.n) - ARITH_W'(1);
    is_last_c = (x_ext == last_ext);
    hs_c      = word_valid_q & bus.word_ready;
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    n_d          = n_q;
    count_d      = count_q;
    word_valid_d = word_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        word_valid_d = 1'b0;
        busy_d       = 1'b0;
        if (bus.start) begin
          n_d          = bus.n;
          word_d       = WORD_W'(first_ext);
          count_d      = '0;
          word_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (hs_c) begin
          count_d = count_q + COUNT_W'(1);
          if (is_last_c) begin
            word_valid_d = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b1;
            state_d      = FIN;
          end else begin
            word_d = WORD_W'(next_ext);
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        word_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      n_q          <= '0;
      count_q      <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      n_q          <= n_d;
      count_q      <= count_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
